// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory responder slice.
// Holds the FSM state encoding, the request-kind encoding, the data word
// width and the wait-counter width.
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_RD,
        REQ_WR,
        REQ_ERR
    } req_kind_t;

endpackage

// File: rtl/mips_mem_array.sv
// Single-port word RAM: synchronous write, registered read.
// Read data is only updated by a read access, so dout holds the last word
// read across writes and idle cycles. Contents are never reset.
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [WORD_W-1:0]     din,
    output logic [WORD_W-1:0]     dout
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_W-1:0] mem [DEPTH];

    // One access per enable: write the word, or register the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= din;
            end else begin
                dout <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS CPU memory port.
// Accepts read/write strobes, waits WAIT_STATES cycles, performs the word
// access on the edge entering RESP and pulses mem_ready for one cycle.
// Optional feature: define MIPS_MEM_ALIGN_CHECK_EN to turn accesses with
// addr[1:0] != 0 into error responses; otherwise the low bits are ignored.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam logic [WCNT_W-1:0] WS_INIT = WCNT_W'(WAIT_STATES);

    state_t                state, state_d;
    logic [WCNT_W-1:0]     wcnt, wcnt_d;
    req_kind_t             kind_q, kind_d;
    req_kind_t             new_kind;
    req_kind_t             acc_kind;
    logic                  enter_resp;
    logic                  misaligned;
    logic                  rdata_zero;
    logic                  arr_en;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] idx;
    logic [WORD_W-1:0]     arr_dout;

    // Higher address bits alias onto the same words.
    assign idx = addr[ADDR_WIDTH+1:2];

`ifdef MIPS_MEM_ALIGN_CHECK_EN
    logic unused_addr;
    assign misaligned  = (addr[1:0] != 2'b00);
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];
`else
    logic unused_addr;
    assign misaligned  = 1'b0;
    assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
`endif

    // Classify the request presented on the strobes at accept time.
    always_comb begin
        new_kind = REQ_NONE;
        if (mem_read && mem_write) begin
            new_kind = REQ_ERR;
        end else if (mem_read || mem_write) begin
            if (misaligned) begin
                new_kind = REQ_ERR;
            end else if (mem_read) begin
                new_kind = REQ_RD;
            end else begin
                new_kind = REQ_WR;
            end
        end
    end

    // Next-state logic; enter_resp marks the edge that performs the access.
    always_comb begin
        state_d    = state;
        wcnt_d     = wcnt;
        kind_d     = kind_q;
        enter_resp = 1'b0;
        acc_kind   = kind_q;
        case (state)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    kind_d = new_kind;
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                        acc_kind   = new_kind;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WS_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!mem_read && !mem_write) begin
                    // Requester withdrew: drop the request without an access.
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                    kind_d  = REQ_NONE;
                end else begin
                    wcnt_d = wcnt - 1'b1;
                    if (wcnt == WCNT_W'(1)) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                kind_d  = REQ_NONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, wait counter and request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            wcnt   <= '0;
            kind_q <= REQ_NONE;
        end else begin
            state  <= state_d;
            wcnt   <= wcnt_d;
            kind_q <= kind_d;
        end
    end

    // Response flags; rdata_zero forces rdata to 0 after reset or an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ready  <= 1'b0;
            mem_err    <= 1'b0;
            rdata_zero <= 1'b1;
        end else begin
            mem_ready <= enter_resp;
            mem_err   <= enter_resp && (acc_kind == REQ_ERR);
            if (enter_resp && acc_kind == REQ_RD) begin
                rdata_zero <= 1'b0;
            end else if (enter_resp && acc_kind == REQ_ERR) begin
                rdata_zero <= 1'b1;
            end
        end
    end

    // Gating with rst drops any write that would land while reset is held.
    assign arr_en = enter_resp && !rst &&
                    (acc_kind == REQ_RD || acc_kind == REQ_WR);
    assign arr_we = (acc_kind == REQ_WR);

    mips_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk (clk),
        .en  (arr_en),
        .we  (arr_we),
        .idx (idx),
        .din (wdata),
        .dout(arr_dout)
    );

    assign rdata = rdata_zero ? '0 : arr_dout;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Testbench for mips_mem_responder: one instance with WAIT_STATES=2 and
// one with WAIT_STATES=0, directed table, corner sequences and random
// traffic checked against a word-array model.
module tb_mips_mem_responder;

    localparam int AW = 10;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
    localparam bit AL = 1'b1;
`else
    localparam bit AL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] ad   [2];
    logic [31:0] wd   [2];
    logic [31:0] rdat [2];
    logic        rdy  [2];
    logic        er   [2];

    int checks = 0;
    int errors = 0;

    mips_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut_ws2 (
        .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]),
        .addr(ad[0]), .wdata(wd[0]), .rdata(rdat[0]),
        .mem_ready(rdy[0]), .mem_err(er[0])
    );

    mips_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]),
        .addr(ad[1]), .wdata(wd[1]), .rdata(rdat[1]),
        .mem_ready(rdy[1]), .mem_err(er[1])
    );

    always #5 clk = ~clk;

    // Reference model: word arrays per instance plus the last response data.
    logic [31:0] mmem  [2][1024];
    bit          mval  [2][1024];
    logic [31:0] mrd   [2];
    bit          mrd_k [2];

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] dat;
        bit          e;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic void model_apply(input int d, input bit r, input bit w,
                                        input logic [31:0] a, input logic [31:0] dat,
                                        output bit e);
        int i;
        i = int'(a[AW+1:2]);
        e = (r && w) || (AL && (a[1:0] != 2'b00));
        if (e) begin
            mrd[d]   = 32'h0;
            mrd_k[d] = 1'b1;
        end else if (w) begin
            mmem[d][i] = dat;
            mval[d][i] = 1'b1;
        end else begin
            mrd[d]   = mmem[d][i];
            mrd_k[d] = mval[d][i];
        end
    endfunction

    // Issue one request, wait (bounded) for mem_ready, check latency and pulse width.
    task automatic txn(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] dat, input string tag,
                       output logic [31:0] got_rd, output logic got_err);
        int lat;
        bit seen;
        @(negedge clk);
        rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = dat;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rdy[d]) seen = 1'b1;
        end
        got_rd  = rdat[d];
        got_err = er[d];
        rd[d] = 1'b0; wr[d] = 1'b0;
        check($sformatf("%s_latency", tag), 32'(lat), 32'(ws_of(d) + 1));
        @(posedge clk); #1;
        check($sformatf("%s_pulse_width", tag), 32'(rdy[d]), 32'h0);
    endtask

    // Transaction checked against the model.
    task automatic mtxn(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] dat, input string tag);
        logic [31:0] g;
        logic        ge;
        bit          e;
        txn(d, r, w, a, dat, tag, g, ge);
        model_apply(d, r, w, a, dat, e);
        check($sformatf("%s_err", tag), 32'(ge), 32'(e));
        if (mrd_k[d]) check($sformatf("%s_rdata", tag), g, mrd[d]);
    endtask

    initial begin
        logic [31:0] g;
        logic        ge;
        bit          e;
        bit          bad;

        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = '0; wd[d] = '0;
            mrd[d] = '0; mrd_k[d] = 1'b1;
            for (int i = 0; i < 1024; i++) mval[d][i] = 1'b0;
        end

        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_1234, 1'b0, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_1234};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1'b0, 32'h0000_1234};
        tbl[5]  = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_0055, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_0044, 32'h0BAD_0044, 1'b0, 32'hCAFE_F00D};
        tbl[8]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'hCAFE_F00D};
        tbl[9]  = '{1'b0, 1'b1, 32'h0000_0002, 32'h2222_2222, AL,
                    AL ? 32'h0 : 32'hCAFE_F00D};
        tbl[10] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0,
                    AL ? 32'h1111_1111 : 32'h2222_2222};
        tbl[11] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h7654_3210, 1'b0,
                    AL ? 32'h1111_1111 : 32'h2222_2222};
        tbl[12] = '{1'b1, 1'b0, 32'h0000_3FFC, 32'h0,         1'b0, 32'h7654_3210};
        tbl[13] = '{1'b1, 1'b0, 32'h0000_0012, 32'h0,         AL,
                    AL ? 32'h0 : 32'hDEAD_BEEF};

        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_rdata_%0d", d), rdat[d], 32'h0);
            check($sformatf("reset_ready_%0d", d), 32'(rdy[d]), 32'h0);
            check($sformatf("reset_err_%0d", d), 32'(er[d]), 32'h0);
        end

        // Directed table on the WAIT_STATES=2 instance
        for (int i = 0; i < 14; i++) begin
            txn(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].dat, $sformatf("tbl%0d", i), g, ge);
            model_apply(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].dat, e);
            check($sformatf("tbl%0d_err", i), 32'(ge), 32'(tbl[i].e));
            check($sformatf("tbl%0d_rdata", i), g, tbl[i].exp_rd);
        end

        // Zero wait states: back-to-back reads with the strobe held high
        mtxn(1, 1'b0, 1'b1, 32'h0, 32'hA5A5_0001, "b2b_prewr0");
        mtxn(1, 1'b0, 1'b1, 32'h4, 32'hA5A5_0002, "b2b_prewr4");
        @(negedge clk);
        rd[1] = 1'b1; ad[1] = 32'h0;
        @(posedge clk); #1;
        check("b2b_pulse1", 32'(rdy[1]), 32'h1);
        check("b2b_rdata1", rdat[1], 32'hA5A5_0001);
        ad[1] = 32'h4;
        @(posedge clk); #1;
        check("b2b_gap", 32'(rdy[1]), 32'h0);
        @(posedge clk); #1;
        check("b2b_pulse2", 32'(rdy[1]), 32'h1);
        check("b2b_rdata2", rdat[1], 32'hA5A5_0002);
        rd[1] = 1'b0;
        @(posedge clk); #1;
        check("b2b_end", 32'(rdy[1]), 32'h0);
        mrd[1] = 32'hA5A5_0002; mrd_k[1] = 1'b1;

        // Abort during WAIT, for a read and for a write
        mtxn(0, 1'b0, 1'b1, 32'h80, 32'h1357_2468, "abort_prewr");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rd[0] = (k == 0); wr[0] = (k == 1); ad[0] = 32'h80; wd[0] = 32'hFFFF_0000;
            @(posedge clk);
            @(negedge clk);
            rd[0] = 1'b0; wr[0] = 1'b0;
            bad = 1'b0;
            repeat (6) begin
                @(posedge clk); #1;
                if (rdy[0]) bad = 1'b1;
            end
            check($sformatf("abort%0d_no_ready", k), 32'(bad), 32'h0);
            mtxn(0, 1'b1, 1'b0, 32'h80, 32'h0, $sformatf("abort%0d_readback", k));
        end

        // Reset in the middle of a write
        mtxn(0, 1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, "rstw_prewr");
        mtxn(0, 1'b1, 1'b0, 32'h20, 32'h0, "rstw_preread");
        @(negedge clk);
        wr[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'hAAAA_5555;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstw_rdata", rdat[0], 32'h0);
        check("rstw_ready", 32'(rdy[0]), 32'h0);
        check("rstw_err", 32'(er[0]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        wr[0] = 1'b0;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mrd[d] = 32'h0; mrd_k[d] = 1'b1;
        end
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rdy[0]) bad = 1'b1;
        end
        check("rstw_no_ready", 32'(bad), 32'h0);
        mtxn(0, 1'b1, 1'b0, 32'h20, 32'h0, "rstw_readback");
        check("rstw_old_value", rdat[0], 32'h0BAD_F00D);

        // Random traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 60; n++) begin
                int          k;
                logic [31:0] a;
                bit          r;
                bit          w;
                k = $urandom_range(0, 9);
                r = (k < 5) || (k == 9);
                w = (k >= 5);
                a = ($urandom_range(0, 7) << 12) | ($urandom_range(0, 15) << 2);
                if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                mtxn(d, r, w, a, $urandom, $sformatf("rnd%0d_%0d", d, n));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
